result_streamer: RTL and testbench

- Downstream consumer of the matrix processor's `result`/`done` outputs.
- On each rising edge of `done`, snapshots the full WIDTH x WIDTH x 32-bit result matrix into an internal frame buffer.
- Streams the matrix out one 32-bit element per beat, row-major, over a valid/ready handshake, tagged with row/col indices and a last flag.
- Decouples the processor's single-cycle result from a slower host/UART/test sink.

---
 rtl/result_streamer_pkg.sv | 17 +
 rtl/result_streamer_if.sv | 24 ++
 rtl/result_streamer_frame_buffer.sv | 51 +++++
 rtl/result_streamer.sv | 111 +++++++++++
 tb/tb_result_streamer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_streamer_pkg.sv
// Shared constants and state encoding for the result streamer slice.
// Optional checksum beat is enabled by defining RESULT_STREAMER_CHECKSUM_EN.
package result_streamer_pkg;

  localparam int WIDTH_BIT_DEF = 2;
  localparam int RS_DATA_W     = 32;
  localparam int FRAME_CNT_W   = 16;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_STREAM = ST_STREAM
  } state_e;

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready element stream carrying one matrix element per beat with row/col tags.
interface result_streamer_if #(
  parameter int WIDTH_BIT = 2,
  parameter int DATA_W    = 32
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [WIDTH_BIT-1:0] out_row;
  logic [WIDTH_BIT-1:0] out_col;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/result_streamer_frame_buffer.sv
// N-entry snapshot of the result matrix with parallel load and indexed read.
// With RESULT_STREAMER_CHECKSUM_EN the XOR of all elements is captured alongside.
module result_frame_buffer
  import result_streamer_pkg::*;
#(
  parameter  int WIDTH_BIT = WIDTH_BIT_DEF,
  parameter  int DATA_W    = RS_DATA_W,
  localparam int N         = 2 ** (2 * WIDTH_BIT)
) (
  input  logic                   CLK,
  input  logic                   load,
  input  logic [N*DATA_W-1:0]    result,
  input  logic [2*WIDTH_BIT-1:0] rd_idx,
  output logic [DATA_W-1:0]      rd_data
`ifdef RESULT_STREAMER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]      csum
`endif
);

  logic [DATA_W-1:0] mem [N];

  // Element (0,0) lives in the MSBs of the flattened bus.
  always_ff @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= result[(N-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem[rd_idx];

`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_d;

  always_comb begin
    csum_d = '0;
    for (int i = 0; i < N; i++) begin
      csum_d = csum_d ^ result[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      csum <= csum_d;
    end
  end
`endif

endmodule

// File: rtl/result_streamer.sv
// Captures the processor result matrix on each rising edge of done and streams it row-major.
// Define RESULT_STREAMER_CHECKSUM_EN to append an XOR checksum beat to every frame.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter  int WIDTH_BIT = WIDTH_BIT_DEF,
  parameter  int DATA_W    = RS_DATA_W,
  localparam int N         = 2 ** (2 * WIDTH_BIT)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   done,
  input  logic [N*DATA_W-1:0]    result,
  result_streamer_if.master      st,
  output logic                   busy,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam int IDX_W    = 2 * WIDTH_BIT + 1;
  localparam int LAST_IDX = N;
`else
  localparam int IDX_W    = 2 * WIDTH_BIT;
  localparam int LAST_IDX = N - 1;
`endif

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic              done_q;
  logic              cap;
  logic              accept;
  logic              last_beat;
  logic              load;
  logic              cs_beat;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] beat_data;

  assign cap       = done & ~done_q;
  assign busy      = (state == S_STREAM);
  assign accept    = busy & st.out_ready;
  assign last_beat = (idx == IDX_W'(LAST_IDX));
  // Reload only when idle or when the final beat leaves in the same cycle.
  assign load      = cap & (~busy | (accept & last_beat));

`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  result_frame_buffer #(.WIDTH_BIT(WIDTH_BIT), .DATA_W(DATA_W)) u_buf (
    .CLK     (CLK),
    .load    (load),
    .result  (result),
    .rd_idx  (idx[2*WIDTH_BIT-1:0]),
    .rd_data (rd_data),
    .csum    (csum)
  );

  assign cs_beat   = (idx == IDX_W'(N));
  assign beat_data = cs_beat ? csum : rd_data;
`else
  result_frame_buffer #(.WIDTH_BIT(WIDTH_BIT), .DATA_W(DATA_W)) u_buf (
    .CLK     (CLK),
    .load    (load),
    .result  (result),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  assign cs_beat   = 1'b0;
  assign beat_data = rd_data;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      idx       <= '0;
      done_q    <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done_q <= done;
      case (state)
        S_IDLE: begin
          if (cap) begin
            idx   <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept && last_beat) begin
            frame_cnt <= frame_cnt + 1'b1;
            idx       <= '0;
            if (!cap) state <= S_IDLE;
          end else begin
            if (accept) idx <= idx + IDX_W'(1);
            if (cap) overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat fields come straight from registered state and the frozen buffer.
  assign st.out_valid = busy;
  assign st.out_data  = busy ? beat_data : '0;
  assign st.out_row   = !busy ? '0 : (cs_beat ? '1 : idx[2*WIDTH_BIT-1:WIDTH_BIT]);
  assign st.out_col   = !busy ? '0 : (cs_beat ? '1 : idx[WIDTH_BIT-1:0]);
  assign st.out_last  = busy & last_beat;

endmodule

// File: tb/tb_result_streamer.sv
// Randomized self-checking bench for result_streamer against a queue-based frame model.
module tb_result_streamer;
  import result_streamer_pkg::*;

  localparam int WB = 2;
  localparam int W  = 1 << WB;
  localparam int N  = W * W;
  localparam int DW = 32;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int BEATS = N + (CS ? 1 : 0);

  typedef struct {
    logic [DW-1:0] d;
    logic [WB-1:0] r;
    logic [WB-1:0] c;
    logic          l;
  } beat_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              done = 1'b0;
  logic [N*DW-1:0]   result = '0;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_cnt;

  result_streamer_if #(.WIDTH_BIT(WB), .DATA_W(DW)) sif ();

  result_streamer #(.WIDTH_BIT(WB), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .done      (done),
    .result    (result),
    .st        (sif),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of beats still owed to the sink.
  beat_t       mq[$];
  logic        m_done_q = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_frames = '0;

  task automatic push_frame(input logic [N*DW-1:0] v);
    logic [DW-1:0] x;
    logic [DW-1:0] e;
    beat_t b;
    x = '0;
    for (int i = 0; i < N; i++) begin
      e = v[(N-1-i)*DW +: DW];
      x = x ^ e;
      b.d = e; b.r = WB'(i / W); b.c = WB'(i % W); b.l = (i == N-1) && !CS;
      mq.push_back(b);
    end
    if (CS) begin
      b.d = x; b.r = '1; b.c = '1; b.l = 1'b1;
      mq.push_back(b);
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_done_q = 1'b0;
      m_ovr    = 1'b0;
      m_frames = '0;
    end else begin
      bit cap, acc, fin;
      cap = done && !m_done_q;
      m_done_q = done;
      acc = (mq.size() > 0) && sif.out_ready;
      fin = acc && (mq.size() == 1);
      if (acc) void'(mq.pop_front());
      if (fin) m_frames = m_frames + 16'd1;
      if (cap) begin
        if (mq.size() == 0) push_frame(result);
        else m_ovr = 1'b1;
      end
    end
  end

  beat_t acc_log[$];

  always @(negedge CLK) begin
    chk("valid", DW'(sif.out_valid), DW'(mq.size() > 0));
    chk("busy", DW'(busy), DW'(mq.size() > 0));
    chk("overrun", DW'(overrun), DW'(m_ovr));
    chk("frame_cnt", DW'(frame_cnt), DW'(m_frames));
    if (mq.size() > 0) begin
      chk("data", sif.out_data, mq[0].d);
      chk("row", DW'(sif.out_row), DW'(mq[0].r));
      chk("col", DW'(sif.out_col), DW'(mq[0].c));
      chk("last", DW'(sif.out_last), DW'(mq[0].l));
    end
    if (sif.out_valid && sif.out_ready) begin
      beat_t b;
      b.d = sif.out_data; b.r = sif.out_row; b.c = sif.out_col; b.l = sif.out_last;
      acc_log.push_back(b);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!sif.out_valid) break;
      step();
    end
    if (k == 300) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_beats(input int n);
    int k;
    for (k = 0; k < 300; k++) begin
      if (acc_log.size() >= n) break;
      step();
    end
    if (k == 300) chk("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    done = 1'b0;
    step(); step();
    RST = 1'b1;
    step();
  endtask

  logic [N*DW-1:0] frame_a;
  logic [DW-1:0]   basic_exp [N];

  initial begin
    sif.out_ready = 1'b0;
    for (int i = 0; i < N; i++) basic_exp[i] = DW'(16 * (i / W) + (i % W));

    // Reset and idle
    do_reset();
    repeat (10) step();
    chk("idle_valid", DW'(sif.out_valid), 32'd0);
    chk("idle_busy", DW'(busy), 32'd0);
    chk("idle_overrun", DW'(overrun), 32'd0);
    chk("idle_frame_cnt", DW'(frame_cnt), 32'd0);

    // Basic frame with done held high across the frame
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = DW'(16 * (i / W) + (i % W));
    sif.out_ready = 1'b1;
    acc_log.delete();
    done = 1'b1;
    chk("pre_edge_valid", DW'(sif.out_valid), 32'd0);
    step();
    chk("latency_valid", DW'(sif.out_valid), 32'd1);
    wait_idle();
    done = 1'b0;
    step();
    chk("basic_beats", acc_log.size(), BEATS);
    for (int i = 0; i < N && i < acc_log.size(); i++) begin
      chk("basic_data", acc_log[i].d, basic_exp[i]);
      chk("basic_last", DW'(acc_log[i].l), DW'((i == N-1) && !CS));
    end
    chk("basic_frame_cnt", DW'(frame_cnt), 32'd1);

    // Backpressure 1,0,0 pattern
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = $urandom;
    acc_log.delete();
    done = 1'b1;
    for (int k = 0; k < 200; k++) begin
      sif.out_ready = (k % 3 == 0);
      step();
      done = 1'b0;
      if (!sif.out_valid && k > 2) break;
    end
    sif.out_ready = 1'b1;
    chk("bp_beats", acc_log.size(), BEATS);

    // Overrun: second edge at beat 5 is dropped
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = $urandom;
    frame_a = result;
    acc_log.delete();
    done = 1'b1;
    step();
    done = 1'b0;
    wait_beats(5);
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = $urandom;
    done = 1'b1;
    step();
    done = 1'b0;
    wait_idle();
    repeat (3) step();
    chk("ovr_beats", acc_log.size(), BEATS);
    for (int i = 0; i < N && i < acc_log.size(); i++)
      chk("ovr_data", acc_log[i].d, frame_a[(N-1-i)*DW +: DW]);
    chk("ovr_sticky", DW'(overrun), 32'd1);

    // Back-to-back frames
    do_reset();
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = $urandom;
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sif.out_valid && sif.out_last) break;
      step();
    end
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = 32'hA000 + i;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("b2b_valid", DW'(sif.out_valid), 32'd1);
    chk("b2b_data0", sif.out_data, 32'hA000);
    chk("b2b_row0", DW'(sif.out_row), 32'd0);
    chk("b2b_col0", DW'(sif.out_col), 32'd0);
    chk("b2b_cnt1", DW'(frame_cnt), 32'd1);
    chk("b2b_overrun", DW'(overrun), 32'd0);
    wait_idle();
    chk("b2b_cnt2", DW'(frame_cnt), 32'd2);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = $urandom;
      sif.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) done = ~done;
      step();
    end
    done = 1'b0;
    sif.out_ready = 1'b1;
    wait_idle();

    // Mid-frame reset
    do_reset();
    acc_log.delete();
    done = 1'b1;
    step();
    done = 1'b0;
    wait_beats(7);
    RST = 1'b0;
    #1;
    chk("rst_valid", DW'(sif.out_valid), 32'd0);
    chk("rst_data", sif.out_data, 32'd0);
    chk("rst_row", DW'(sif.out_row), 32'd0);
    chk("rst_col", DW'(sif.out_col), 32'd0);
    chk("rst_last", DW'(sif.out_last), 32'd0);
    chk("rst_busy", DW'(busy), 32'd0);
    chk("rst_frame_cnt", DW'(frame_cnt), 32'd0);
    step(); step();
    RST = 1'b1;
    step();

    // All-ones frame: checksum beat cancels to zero when enabled
    for (int i = 0; i < N; i++) result[(N-1-i)*DW +: DW] = 32'h1;
    acc_log.delete();
    done = 1'b1;
    step();
    done = 1'b0;
    wait_idle();
    step();
    chk("ones_beats", acc_log.size(), BEATS);
    if (acc_log.size() == BEATS) begin
      chk("ones_last_data", acc_log[BEATS-1].d, CS ? 32'h0 : 32'h1);
      chk("ones_last_row", DW'(acc_log[BEATS-1].r), 32'd3);
      chk("ones_last_col", DW'(acc_log[BEATS-1].c), 32'd3);
      chk("ones_last_flag", DW'(acc_log[BEATS-1].l), 32'd1);
      chk("ones_prev_flag", DW'(acc_log[BEATS-2].l), 32'd0);
    end
    chk("ones_frame_cnt", DW'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
